axis_requant: RTL and testbench



---
 rtl/axis_requant.sv | 103 ++++++++++
 tb/tb_axis_requant.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_requant.sv
// axis_requant: per-column bias add, rounding arithmetic shift, optional ReLU and
// saturation of systolic-array partial sums on a backpressured AXIS stream.
module axis_requant #(
  parameter int R  = 4,
  parameter int C  = 8,
  parameter int WY = 16,
  parameter int WB = 16,
  parameter int WO = 8,
  parameter int WS = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  input  logic [R*WY-1:0] s_data,
  input  logic [C*WB-1:0] bias_data,
  input  logic [WS-1:0]   cfg_shift,
  input  logic            cfg_relu,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic [R*WO-1:0] m_data,
  output logic            err
);
  localparam int CW = C > 1 ? $clog2(C) : 1;
  localparam int WT = WY + 3;
  localparam logic signed [WT-1:0] MX = WT'(2**(WO-1) - 1);
  localparam logic signed [WT-1:0] MN = ~MX;
  localparam logic [WS-1:0] SMAX = WS'(WY + 1);
  logic                 en, acc, first, valid1, last1, relu1, relu_reg, relu_sel;
  logic [CW-1:0]        col;
  logic [C*WB-1:0]      bias_reg;
  logic [WS-1:0]        shift_reg, shift1, shift_sel;
  logic signed [WB-1:0] bias_sel;
  logic signed [WY:0]   sum_c [R];
  logic signed [WY:0]   sum1 [R];
  logic [R*WO-1:0]      res;

  // Any shift beyond WY+1 rounds to the same result, so the shifter is clamped there.
  function automatic logic [WO-1:0] requant(input logic signed [WY:0] s,
                                            input logic [WS-1:0] sh, input logic rl);
    logic [WS-1:0]        k;
    logic signed [WT-1:0] t;
    k = sh > SMAX ? SMAX : sh;
    t = {{2{s[WY]}}, s} + (k == '0 ? '0 : WT'(1) << (k - WS'(1)));
    t = t >>> k;
    t = rl && t < 0 ? '0 : t;
    return t > MX ? MX[WO-1:0] : t < MN ? MN[WO-1:0] : t[WO-1:0];
  endfunction

  assign en        = !m_valid || m_ready;
  assign s_ready   = en;
  assign acc       = s_valid && en;
  assign first     = col == '0;
  // Column 0 uses the live bias/cfg since the registered copy is loaded on that same beat.
  assign bias_sel  = first ? bias_data[WB-1:0] : bias_reg[col*WB +: WB];
  assign shift_sel = first ? cfg_shift : shift_reg;
  assign relu_sel  = first ? cfg_relu : relu_reg;

  for (genvar i = 0; i < R; i++) begin : g_lane
    assign sum_c[i] = {s_data[i*WY+WY-1], s_data[i*WY +: WY]}
                    + {{(WY+1-WB){bias_sel[WB-1]}}, bias_sel};
    assign res[i*WO +: WO] = requant(sum1[i], shift1, relu1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid1    <= 1'b0;
      last1     <= 1'b0;
      relu1     <= 1'b0;
      shift1    <= '0;
      col       <= '0;
      err       <= 1'b0;
      bias_reg  <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
    end else begin
      if (en) begin
        valid1  <= acc;
        m_valid <= valid1;
        m_last  <= last1;
        if (valid1) m_data <= res;
      end
      if (acc) begin
        for (int r = 0; r < R; r++) sum1[r] <= sum_c[r];
        last1  <= s_last;
        relu1  <= relu_sel;
        shift1 <= shift_sel;
        col    <= s_last || col == CW'(C-1) ? '0 : col + CW'(1);
        err    <= err | (s_last != (col == CW'(C-1)));
        if (first) begin
          bias_reg  <= bias_data;
          shift_reg <= cfg_shift;
          relu_reg  <= cfg_relu;
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_requant.sv
// tb_axis_requant: directed plus randomized packets checked against an arithmetic reference model.
module tb_axis_requant;
  localparam int R = 4, C = 8, WY = 16, WB = 16, WO = 8, WS = 5;
  logic clk = 0, rstn = 0;
  logic s_valid = 0, s_ready, s_last = 0;
  logic [R*WY-1:0] s_data = '0;
  logic [C*WB-1:0] bias_data = '0;
  logic [WS-1:0] cfg_shift = '0;
  logic cfg_relu = 0;
  logic m_valid, m_ready = 1, m_last, err;
  logic [R*WO-1:0] m_data;

  always #5 clk = ~clk;

  axis_requant #(.R(R), .C(C), .WY(WY), .WB(WB), .WO(WO), .WS(WS)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_data(s_data), .bias_data(bias_data), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data), .err(err)
  );

  typedef struct { logic [R*WO-1:0] d; logic l; int n; int s; } exp_t;
  exp_t q[$];
  logic [R*WO-1:0] obs[$];
  logic obs_l[$];
  bit mr_q[$];
  longint bias_m[C];
  int checks = 0, errors = 0, col_m = 0, shift_m = 0, cyc_n = 0, stalls = 0, b;
  bit relu_m = 0, err_m = 0, stalled = 0, acc_flag = 0, mr_rand = 0;
  logic [R*WO-1:0] prev_d;
  logic prev_l;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [WO-1:0] ref_q(input longint s, input int sh, input bit rl);
    longint t, hi;
    hi = (longint'(1) << (WO-1)) - 1;
    t = (s + (sh > 0 ? (longint'(1) << (sh - 1)) : longint'(0))) >>> sh;
    if (rl && t < 0) t = 0;
    if (t > hi) t = hi;
    if (t < -hi - 1) t = -hi - 1;
    return t[WO-1:0];
  endfunction

  function automatic logic [R*WY-1:0] pk(input int a, input int b2, input int c, input int d);
    return {16'(d), 16'(c), 16'(b2), 16'(a)};
  endfunction

  function automatic logic [R*WY-1:0] rnd_data();
    logic [R*WY-1:0] v;
    for (int r = 0; r < R; r++) v[r*WY +: WY] = WY'($urandom);
    return v;
  endfunction

  task automatic eval();
    logic [R*WO-1:0] d;
    exp_t e;
    if (!rstn) begin
      q.delete(); col_m = 0; err_m = 0; stalled = 0;
      return;
    end
    chk("err", err, err_m);
    chk("s_ready", s_ready, !(m_valid && !m_ready));
    if (stalled) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, prev_d);
      chk("hold_last", m_last, prev_l);
    end
    if (m_valid && m_ready) begin
      if (q.size() == 0) chk("spurious_out", m_valid, 0);
      else begin
        e = q.pop_front();
        chk("data", m_data, e.d);
        chk("last", m_last, e.l);
        chk("latency", cyc_n - e.n, 2 + stalls - e.s);
      end
      obs.push_back(m_data);
      obs_l.push_back(m_last);
    end
    if (s_valid && s_ready) begin
      if (col_m == 0) begin
        for (int c = 0; c < C; c++) bias_m[c] = longint'($signed(bias_data[c*WB +: WB]));
        shift_m = int'(cfg_shift);
        relu_m = cfg_relu;
      end
      for (int r = 0; r < R; r++)
        d[r*WO +: WO] = ref_q(longint'($signed(s_data[r*WY +: WY])) + bias_m[col_m], shift_m, relu_m);
      e = '{d, s_last, cyc_n, stalls};
      q.push_back(e);
      if (s_last != (col_m == C-1)) err_m = 1;
      col_m = (s_last || col_m == C-1) ? 0 : col_m + 1;
      acc_flag = 1;
    end
    stalled = m_valid && !m_ready;
    if (stalled) stalls++;
    prev_d = m_data;
    prev_l = m_last;
  endtask

  task automatic cyc();
    m_ready = mr_q.size() > 0 ? mr_q.pop_front() : (mr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    #1;
    eval();
    @(posedge clk);
    cyc_n++;
    #2;
  endtask

  task automatic send(input logic [R*WY-1:0] data, input logic last);
    s_valid = 1; s_data = data; s_last = last;
    acc_flag = 0;
    for (int k = 0; k < 100 && !acc_flag; k++) cyc();
    if (!acc_flag) chk("accept_timeout", acc_flag, 1);
  endtask

  task automatic idle();
    s_valid = 0; s_last = 0;
    cyc();
  endtask

  task automatic pkt(input logic [R*WY-1:0] first, input int n, input bit rnd, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send((i == 0 || !rnd) ? first : rnd_data(), i == n - 1);
      if (gaps && $urandom_range(0, 3) == 0) idle();
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic drain();
    s_valid = 0; s_last = 0;
    for (int i = 0; i < 300 && q.size() > 0; i++) cyc();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rstn = 0; s_valid = 0; s_last = 0;
    cyc(); cyc();
    rstn = 1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 1);
  endtask

  task automatic set_bias(input int base, input int step);
    for (int c = 0; c < C; c++) bias_data[c*WB +: WB] = WB'(base + c * step);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #2;
    do_reset();
    // rounding on bias-added sums
    set_bias(0, 0); bias_data[WB-1:0] = 16'd28; cfg_shift = 2; cfg_relu = 0;
    b = obs.size();
    pkt(pk(100, 100, 100, 100), C, 1, 0);
    drain();
    chk("t1_round", obs[b], 32'h20202020);
    // saturation and ReLU
    set_bias(0, 0); cfg_shift = 0;
    b = obs.size();
    pkt(pk(1000, -1000, 127, -128), C, 1, 0);
    cfg_relu = 1;
    pkt(pk(1000, -1000, 127, -128), C, 1, 0);
    drain();
    chk("t2_sat", obs[b], 32'h807f807f);
    chk("t2_relu", obs[b+C], 32'h007f007f);
    // round half up
    cfg_relu = 0; cfg_shift = 1;
    b = obs.size();
    pkt(pk(5, -5, 4, -4), C, 1, 0);
    drain();
    chk("t3_half", obs[b], 32'hfe02fe03);
    // stall mid-packet with per-column bias
    set_bias(0, 1); cfg_shift = 0;
    b = obs.size();
    mr_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pkt(pk(10, 10, 10, 10), C, 0, 0);
    drain();
    chk("t4_count", obs.size() - b, C);
    for (int c = 0; c < C; c++) begin
      chk("t4_col", obs[b+c], {4{8'(10 + c)}});
      chk("t4_last", obs_l[b+c], c == C - 1);
    end
    // short packet sets sticky err, next packet restarts at column 0
    set_bias(3, 2); cfg_shift = 1;
    pkt(rnd_data(), 5, 1, 0);
    drain();
    chk("t5_err", err, 1);
    set_bias(-50, 7);
    b = obs.size();
    pkt(pk(50, 60, 70, 80), C, 1, 0);
    drain();
    chk("t5_bias0", obs[b], {8'd15, 8'd10, 8'd5, 8'd0});
    chk("t5_err_sticky", err, 1);
    // reset mid-packet
    for (int i = 0; i < 3; i++) send(rnd_data(), 0);
    do_reset();
    b = obs.size();
    pkt(rnd_data(), C, 1, 0);
    drain();
    chk("t6_count", obs.size() - b, C);
    chk("t6_last", obs_l[obs_l.size()-1], 1);
    chk("t6_err", err, 0);
    // randomized packets, shifts and backpressure
    mr_rand = 1;
    for (int p = 0; p < 40; p++) begin
      for (int c = 0; c < C; c++) bias_data[c*WB +: WB] = WB'($urandom);
      cfg_shift = WS'($urandom_range(0, 31));
      cfg_relu = 1'($urandom_range(0, 1));
      pkt(rnd_data(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, C)) : C, 1, 1);
    end
    drain();
    mr_rand = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
